// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: shared types and sizing for the serial memory loader.
package uart_mem_loader_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam int WORD_BYTES = 4;
  localparam int MEM_WORDS = 1024;
  localparam int DEF_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_mem_loader_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer; strobes each byte on its stop-bit sample.
module uart_rx_byte
  import uart_mem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       rxErr
);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  logic meta_q, rxs_q, prev_q;
  logic [1:0] live_q;
  rx_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic fall;
  // prev_q only tracks rxs once the synchronizer holds real line samples, so
  // a line already low at reset release is not taken as a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      live_q  <= 2'b00;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      meta_q  <= RxD;
      rxs_q   <= meta_q;
      live_q  <= {live_q[0], 1'b1};
      prev_q  <= live_q[1] & rxs_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end
  assign fall = prev_q & ~rxs_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rxValid = 1'b0;
    rxErr   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = fall ? START : IDLE;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        state_d = rxs_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        sh_d    = {rxs_q, sh_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
        rxValid = rxs_q;
        rxErr   = ~rxs_q;
      end
    endcase
  end
  assign rxData = sh_q;
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: packs received UART bytes into 32-bit words and writes them
// to sequential memory word addresses.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD,
  output logic        writeEn,
  output logic [31:0] address,
  output logic [31:0] dataIn,
  output logic        frameErr,
  output logic [10:0] wordCount
);
  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);
  localparam logic [10:0] WC_MAX = 11'(MEM_WORDS);
  logic [7:0] rx_data;
  logic rx_valid, rx_err;
  logic [1:0] idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic we_q, we_d, fe_q, fe_d;
  logic [9:0] addr_q, addr_d;
  logic [10:0] wc_q, wc_d;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .RxD    (RxD),
    .rxData (rx_data),
    .rxValid(rx_valid),
    .rxErr  (rx_err)
  );
  always_comb begin
    data_d = data_q;
    if (rx_valid) data_d[{idx_q, 3'b000} +: 8] = rx_data;
    idx_d  = rx_err ? 2'd0 : rx_valid ? idx_q + 2'd1 : idx_q;
    we_d   = rx_valid && idx_q == LAST_BYTE;
    fe_d   = rx_err;
    addr_d = we_q ? addr_q + 10'd1 : addr_q;
    wc_d   = (we_q && wc_q != WC_MAX) ? wc_q + 11'd1 : wc_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      fe_q   <= 1'b0;
      addr_q <= '0;
      wc_q   <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      we_q   <= we_d;
      fe_q   <= fe_d;
      addr_q <= addr_d;
      wc_q   <= wc_d;
    end
  end
  assign writeEn   = we_q;
  assign frameErr  = fe_q;
  assign address   = {22'd0, addr_q};
  assign dataIn    = data_q;
  assign wordCount = wc_q;
endmodule
